// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte queue between the UART receiver and the debug engine,
// with a saturating counter of receiver overflow pulses.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_overflow,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic [7:0]    ovf_count,
  input  logic          ovf_clear
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  // Status is derived only from registered pointers, so in_ready never sees out_ready.
  assign empty     = (wp == rp);
  assign full      = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign in_ready  = resetn && !full;
  assign out_valid = !empty;
  assign out_data  = mem[rp[AW-1:0]];
  assign level     = wp - rp;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
    end
  end

  // A clear wins over a coincident overflow pulse; that pulse is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (in_overflow) begin
      ovf_count <= sat_inc(ovf_count);
    end
  end

endmodule
